// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl
//   Selects which pixel stream (unfiltered bypass or one of NUM_FILTERS
//   filter channels) drives the frame-buffer write port. A debounced push
//   button steps through the modes. A mode change is armed on a press and
//   committed only at the first pixel of a frame, so no frame is ever mixed.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   btn_next            raw asynchronous push-button (active-high)
//   we_in/wAddr_in/wData_in   camera write stream (stage S0)
//   f_we/f_addr/f_data  filter channel k in bit/slice k-1 (stage S1)
//   we_out/wAddr_out/wData_out  frame-buffer write port (S1 + 1 register)
//   mode                committed mode (0 = bypass .. NUM_FILTERS)
//   pending             a mode change is armed, waiting for a frame start
//   frame_cnt           frame boundaries seen (wraps)
module filter_mode_ctrl #(
    parameter  int unsigned IMG_WIDTH       = 320,
    parameter  int unsigned IMG_HEIGHT      = 240,
    parameter  int unsigned NUM_FILTERS     = 3,
    parameter  int unsigned DEBOUNCE_CYCLES = 1000000,
    localparam int unsigned AW = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int unsigned MW = $clog2(NUM_FILTERS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_next,
    input  logic                      we_in,
    input  logic [AW-1:0]             wAddr_in,
    input  logic [15:0]               wData_in,
    input  logic [NUM_FILTERS-1:0]    f_we,
    input  logic [NUM_FILTERS*AW-1:0] f_addr,
    input  logic [NUM_FILTERS*16-1:0] f_data,
    output logic                      we_out,
    output logic [AW-1:0]             wAddr_out,
    output logic [15:0]               wData_out,
    output logic [MW-1:0]             mode,
    output logic                      pending,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned    CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MW-1:0]  MODE_MAX  = MW'(NUM_FILTERS);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t          state;
    logic [MW-1:0]   target;

    // Button synchronizer and debouncer
    logic            sync_a, sync_b;
    logic [CW-1:0]   db_cnt;
    logic            stable, stable_q;
    logic            press;

    // Bypass channel registered once so it lines up with the filter outputs
    logic            byp_we;
    logic [AW-1:0]   byp_addr;
    logic [15:0]     byp_data;

    logic            fb;
    logic [MW-1:0]   sel;
    logic            mux_we;
    logic [AW-1:0]   mux_addr;
    logic [15:0]     mux_data;

    function automatic logic [MW-1:0] inc(input logic [MW-1:0] x);
        return (x == MODE_MAX) ? '0 : x + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            db_cnt   <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync_a   <= btn_next;
            sync_b   <= sync_a;
            stable_q <= stable;
            if (sync_b == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                stable <= sync_b;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; releases never count
    assign press = stable & ~stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_we   <= 1'b0;
            byp_addr <= '0;
            byp_data <= '0;
        end else begin
            byp_we   <= we_in;
            byp_addr <= wAddr_in;
            byp_data <= wData_in;
        end
    end

    // Frame start is always taken from the bypass channel, whatever is selected
    assign fb  = byp_we && (byp_addr == '0);
    // In the commit cycle the new target already drives the mux, so the
    // address-0 pixel of the new frame uses the new mode
    assign sel = (state == ARMED && fb) ? target : mode;

    always_comb begin
        mux_we   = byp_we;
        mux_addr = byp_addr;
        mux_data = byp_data;
        for (int unsigned k = 1; k <= NUM_FILTERS; k++) begin
            if (sel == MW'(k)) begin
                mux_we   = f_we[k-1];
                mux_addr = f_addr[(k-1)*AW +: AW];
                mux_data = f_data[(k-1)*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            mode      <= '0;
            pending   <= 1'b0;
            we_out    <= 1'b0;
            wAddr_out <= '0;
            wData_out <= '0;
            frame_cnt <= '0;
        end else begin
            we_out    <= mux_we;
            wAddr_out <= mux_addr;
            wData_out <= mux_data;
            if (fb) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    // A press coinciding with a frame start only arms
                    if (press) begin
                        target  <= inc(mode);
                        state   <= ARMED;
                        pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (fb) begin
                        mode <= target;
                        // Press on the commit cycle re-arms from the committed target
                        if (press) begin
                            target <= inc(target);
                        end else begin
                            state   <= IDLE;
                            pending <= 1'b0;
                        end
                    end else if (press) begin
                        target <= inc(target);
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
module tb_filter_mode_ctrl;

    localparam int unsigned IW  = 16;
    localparam int unsigned IH  = 8;
    localparam int unsigned NF  = 3;
    localparam int unsigned DB  = 4;
    localparam int unsigned AW  = $clog2(IW * IH);
    localparam int unsigned MW  = $clog2(NF + 1);
    localparam int          LAST = IW * IH - 1;

    logic              clk;
    logic              reset;
    logic              btn_next;
    logic              we_in;
    logic [AW-1:0]     wAddr_in;
    logic [15:0]       wData_in;
    logic [NF-1:0]     f_we;
    logic [NF*AW-1:0]  f_addr;
    logic [NF*16-1:0]  f_data;
    logic              we_out;
    logic [AW-1:0]     wAddr_out;
    logic [15:0]       wData_out;
    logic [MW-1:0]     mode;
    logic              pending;
    logic [15:0]       frame_cnt;

    int checks;
    int errors;
    int btn_hold;
    logic prev_we;
    int   prev_addr;

    filter_mode_ctrl #(
        .IMG_WIDTH      (IW),
        .IMG_HEIGHT     (IH),
        .NUM_FILTERS    (NF),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_next (btn_next),
        .we_in    (we_in),
        .wAddr_in (wAddr_in),
        .wData_in (wData_in),
        .f_we     (f_we),
        .f_addr   (f_addr),
        .f_data   (f_data),
        .we_out   (we_out),
        .wAddr_out(wAddr_out),
        .wData_out(wData_out),
        .mode     (mode),
        .pending  (pending),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Camera pixel value for an address
    function automatic logic [15:0] d(input int a);
        return 16'(a * 37 + 16'h00a5);
    endfunction

    // Filter channel k output for a camera value
    function automatic logic [15:0] filt(input int k, input logic [15:0] v);
        return v ^ 16'(k * 16'h1111);
    endfunction

    // One clock: camera pixel at S0, filter outputs of the previous pixel at S1
    task automatic step(input logic we, input int addr);
        btn_next = (btn_hold > 0);
        if (btn_hold > 0) btn_hold--;
        f_we = {NF{prev_we}};
        for (int k = 1; k <= int'(NF); k++) begin
            f_addr[(k-1)*AW +: AW] = AW'(prev_addr);
            f_data[(k-1)*16 +: 16] = filt(k, d(prev_addr));
        end
        we_in    = we;
        wAddr_in = AW'(addr);
        wData_in = d(addr);
        prev_we   = we;
        prev_addr = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixels(input int a0, input int a1);
        for (int a = a0; a <= a1; a++) step(1'b1, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        checks++;
        if ({we_out, wAddr_out, wData_out} !== '0) begin
            errors++;
            $display("FAIL reset_port: got we=%0b addr=%0d data=%h, want 0", we_out, wAddr_out, wData_out);
        end
        checks++;
        if (mode !== '0) begin
            errors++;
            $display("FAIL reset_mode: got %0d, want 0", mode);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: got %0b, want 0", pending);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt);
        end
    endtask

    task automatic test_bypass_frame;
        for (int a = 0; a <= LAST; a++) begin
            step(1'b1, a);
            if (a > 0) begin
                checks++;
                if ({we_out, wAddr_out, wData_out} !== {1'b1, AW'(a - 1), d(a - 1)}) begin
                    errors++;
                    $display("FAIL bypass_px%0d: got we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                             a - 1, we_out, wAddr_out, wData_out, a - 1, d(a - 1));
                end
            end
        end
        step(1'b0, 0);
        checks++;
        if ({we_out, wAddr_out, wData_out} !== {1'b1, AW'(LAST), d(LAST)}) begin
            errors++;
            $display("FAIL bypass_last: got we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                     we_out, wAddr_out, wData_out, LAST, d(LAST));
        end
        step(1'b0, 0);
        checks++;
        if (we_out !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle_we: got %0b, want 0", we_out);
        end
        checks++;
        if ({mode, pending, frame_cnt} !== {MW'(0), 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL bypass_state: got mode=%0d pending=%0b frames=%0d, want 0 0 1", mode, pending, frame_cnt);
        end
    endtask

    task automatic test_short_press;
        btn_hold = 3;
        idle(14);
        checks++;
        if ({mode, pending} !== {MW'(0), 1'b0}) begin
            errors++;
            $display("FAIL short_press: got mode=%0d pending=%0b, want 0 0", mode, pending);
        end
    endtask

    task automatic test_arm_commit;
        run_pixels(0, 49);
        btn_hold = 10;
        run_pixels(50, 79);
        checks++;
        if ({mode, pending} !== {MW'(0), 1'b1}) begin
            errors++;
            $display("FAIL arm_pending: got mode=%0d pending=%0b, want 0 1", mode, pending);
        end
        run_pixels(80, LAST);
        run_pixels(0, 0);
        checks++;
        if ({mode, pending, wData_out} !== {MW'(0), 1'b1, d(LAST)}) begin
            errors++;
            $display("FAIL arm_last_px: got mode=%0d pending=%0b data=%h, want 0 1 %h", mode, pending, wData_out, d(LAST));
        end
        run_pixels(1, 1);
        checks++;
        if ({we_out, wAddr_out, wData_out} !== {1'b1, AW'(0), filt(1, d(0))}) begin
            errors++;
            $display("FAIL commit_px0: got we=%0b addr=%0d data=%h, want we=1 addr=0 data=%h",
                     we_out, wAddr_out, wData_out, filt(1, d(0)));
        end
        checks++;
        if ({mode, pending, frame_cnt} !== {MW'(1), 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL commit_state: got mode=%0d pending=%0b frames=%0d, want 1 0 3", mode, pending, frame_cnt);
        end
    endtask

    task automatic test_double_press_wrap;
        // 1 -> 2 -> 3, committed at the next frame start
        run_pixels(2, 9);
        btn_hold = 6;
        run_pixels(10, 39);
        btn_hold = 6;
        run_pixels(40, LAST);
        run_pixels(0, 1);
        checks++;
        if ({mode, pending, wData_out} !== {MW'(3), 1'b0, filt(3, d(0))}) begin
            errors++;
            $display("FAIL to_mode3: got mode=%0d pending=%0b data=%h, want 3 0 %h", mode, pending, wData_out, filt(3, d(0)));
        end
        // 3 -> 0 -> 1
        run_pixels(2, 9);
        btn_hold = 6;
        run_pixels(10, 39);
        btn_hold = 6;
        run_pixels(40, LAST);
        run_pixels(0, 1);
        checks++;
        if ({mode, pending, wData_out} !== {MW'(1), 1'b0, filt(1, d(0))}) begin
            errors++;
            $display("FAIL wrap_mode1: got mode=%0d pending=%0b data=%h, want 1 0 %h", mode, pending, wData_out, filt(1, d(0)));
        end
        checks++;
        if (frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL wrap_frames: got %0d, want 5", frame_cnt);
        end
    endtask

    task automatic test_press_at_fb;
        run_pixels(2, 9);
        btn_hold = 6;
        run_pixels(10, 122);
        // Button held from pixel 123: debounced press lands in the frame-start cycle
        btn_hold = 6;
        run_pixels(123, LAST);
        run_pixels(0, 1);
        checks++;
        if ({mode, pending, wData_out} !== {MW'(2), 1'b1, filt(2, d(0))}) begin
            errors++;
            $display("FAIL fb_press_commit: got mode=%0d pending=%0b data=%h, want 2 1 %h", mode, pending, wData_out, filt(2, d(0)));
        end
        run_pixels(2, LAST);
        checks++;
        if (wData_out !== filt(2, d(LAST - 1))) begin
            errors++;
            $display("FAIL fb_press_frame: got data=%h, want %h", wData_out, filt(2, d(LAST - 1)));
        end
        run_pixels(0, 1);
        checks++;
        if ({mode, pending, wData_out} !== {MW'(3), 1'b0, filt(3, d(0))}) begin
            errors++;
            $display("FAIL fb_press_next: got mode=%0d pending=%0b data=%h, want 3 0 %h", mode, pending, wData_out, filt(3, d(0)));
        end
    endtask

    task automatic test_reset_mid;
        run_pixels(2, 9);
        btn_hold = 6;
        run_pixels(10, 60);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending: got %0b, want 1", pending);
        end
        reset = 1'b1;
        step(1'b1, 61);
        reset = 1'b0;
        checks++;
        if ({we_out, wAddr_out, wData_out, mode, pending, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got we=%0b addr=%0d data=%h mode=%0d pending=%0b frames=%0d, want all 0",
                     we_out, wAddr_out, wData_out, mode, pending, frame_cnt);
        end
        run_pixels(62, LAST);
        run_pixels(0, 1);
        checks++;
        if ({we_out, wAddr_out, wData_out} !== {1'b1, AW'(0), d(0)}) begin
            errors++;
            $display("FAIL post_reset_px0: got we=%0b addr=%0d data=%h, want we=1 addr=0 data=%h",
                     we_out, wAddr_out, wData_out, d(0));
        end
        checks++;
        if ({mode, pending, frame_cnt} !== {MW'(0), 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL post_reset_state: got mode=%0d pending=%0b frames=%0d, want 0 0 1", mode, pending, frame_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        btn_hold  = 0;
        prev_we   = 1'b0;
        prev_addr = 0;
        reset     = 1'b1;
        btn_next  = 1'b0;
        we_in     = 1'b0;
        wAddr_in  = '0;
        wData_in  = '0;
        f_we      = '0;
        f_addr    = '0;
        f_data    = '0;
        @(posedge clk);
        #1;
        test_reset;
        test_bypass_frame;
        test_short_press;
        test_arm_commit;
        test_double_press_wrap;
        test_press_at_fb;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
